// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline with the IF/ID register.
// Also tracks stall statistics and flags a hazard-unit deadlock via `stuck`.
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h00003000,
  parameter int          IM_AW     = 10,
  parameter int unsigned STALL_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic [31:0]      instr_in,
  output logic [31:0]      PC_F,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      IR_D,
  output logic [31:0]      PC_D,
  output logic [31:0]      PC8_D,
  output logic [31:0]      stall_cnt,
  output logic             stuck
);

  logic [31:0] pc_next;
  logic [7:0]  run_cnt;
  logic [7:0]  run_next;
  logic        stuck_next;

  // PC_F and PC_RESET are both word aligned, so the low two bits never borrow.
  assign im_addr = PC_F[IM_AW+1:2] - PC_RESET[IM_AW+1:2];
  assign PC8_D   = PC_D + 32'd8;

  // Stop outranks redirect: the stalled D instruction re-asserts its redirect.
  always_comb begin
    pc_next = PC_F + 32'd4;
    if (stop) begin
      pc_next = PC_F;
    end else if (redirect) begin
      pc_next = redirect_pc & ~32'h3;
    end
  end

  always_comb begin
    run_next = 8'd0;
    if (stop) begin
      run_next = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
    end
    stuck_next = (32'(run_next) >= STALL_MAX);
  end

  // Delay-slot architecture: a redirect never flushes IF/ID.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_F <= PC_RESET;
      IR_D <= 32'd0;
      PC_D <= PC_RESET;
    end else begin
      PC_F <= pc_next;
      if (!stop) begin
        IR_D <= instr_in;
        PC_D <= PC_F;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      run_cnt   <= 8'd0;
      stuck     <= 1'b0;
    end else begin
      if (stop && (stall_cnt != 32'hFFFFFFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      run_cnt <= run_next;
      stuck   <= stuck_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stalls, redirects,
// PC wrap, deadlock flag and reset during a stall.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stop;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_in;
  logic [31:0] pc_f;
  logic [9:0]  im_addr;
  logic [31:0] ir_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic [31:0] stall_cnt;
  logic        stuck;

  int tests_run = 0;
  int fail_cnt  = 0;
  logic [31:0] exp_q[$];

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stop       (stop),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_in   (instr_in),
    .PC_F       (pc_f),
    .im_addr    (im_addr),
    .IR_D       (ir_d),
    .PC_D       (pc_d),
    .PC8_D      (pc8_d),
    .stall_cnt  (stall_cnt),
    .stuck      (stuck)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: each word encodes its own word index
  assign instr_in = 32'hA000_0000 | {22'd0, im_addr};

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [31:0] off;
    off = (pc - 32'h00003000) >> 2;
    return 32'hA000_0000 | {22'd0, off[9:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pipe(input string tag, input logic [31:0] e_pcf,
                            input logic [31:0] e_ir, input logic [31:0] e_pcd);
    check({tag, ".pc_f"}, pc_f, e_pcf);
    check({tag, ".ir_d"}, ir_d, e_ir);
    check({tag, ".pc_d"}, pc_d, e_pcd);
  endtask

  initial begin
    reset = 1'b1;
    stop = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    step();
    step();
    check_pipe("reset", 32'h3000, 32'h0, 32'h3000);
    check("reset.pc8_d", pc8_d, 32'h3008);
    check("reset.im_addr", {22'd0, im_addr}, 32'd0);
    check("reset.stall_cnt", stall_cnt, 32'd0);
    check("reset.stuck", {31'd0, stuck}, 32'd0);

    // sequential fetch, IR_D lags PC_F by one edge
    reset = 1'b0;
    exp_q.push_back(32'hA000_0000);
    exp_q.push_back(32'hA000_0001);
    step();
    check_pipe("seq0", 32'h3004, exp_q.pop_front(), 32'h3000);
    check("seq0.pc8_d", pc8_d, 32'h3008);
    step();
    check_pipe("seq1", 32'h3008, exp_q.pop_front(), 32'h3004);
    check("seq1.im_addr", {22'd0, im_addr}, 32'd2);

    // redirect keeps the delay slot
    redirect = 1'b1;
    redirect_pc = 32'h3100;
    step();
    check_pipe("redir", 32'h3100, 32'hA000_0002, 32'h3008);
    check("redir.pc8_d", pc8_d, 32'h3010);
    redirect = 1'b0;
    step();
    check_pipe("after_redir", 32'h3104, 32'hA000_0040, 32'h3100);

    redirect = 1'b1;
    redirect_pc = 32'h3010;
    step();
    check_pipe("redir2", 32'h3010, 32'hA000_0041, 32'h3104);
    redirect = 1'b0;

    // two-cycle stall freezes everything
    stop = 1'b1;
    step();
    check_pipe("stall1", 32'h3010, 32'hA000_0041, 32'h3104);
    check("stall1.cnt", stall_cnt, 32'd1);
    step();
    check_pipe("stall2", 32'h3010, 32'hA000_0041, 32'h3104);
    check("stall2.cnt", stall_cnt, 32'd2);
    stop = 1'b0;
    step();
    check_pipe("resume", 32'h3014, word_at(32'h3010), 32'h3010);
    check("resume.cnt", stall_cnt, 32'd2);

    // stop overrides redirect; misaligned target is forced aligned
    stop = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h3200;
    step();
    check_pipe("stop_redir", 32'h3014, 32'hA000_0004, 32'h3010);
    check("stop_redir.cnt", stall_cnt, 32'd3);
    stop = 1'b0;
    redirect_pc = 32'h3203;
    step();
    check_pipe("redir_align", 32'h3200, 32'hA000_0005, 32'h3014);

    // PC wrap at the top of the address space
    redirect_pc = 32'hFFFF_FFFC;
    step();
    check("wrap.pc_f", pc_f, 32'hFFFF_FFFC);
    check("wrap.im_addr", {22'd0, im_addr}, 32'h3FF);
    redirect = 1'b0;
    step();
    check_pipe("wrap0", 32'h0, 32'hA000_03FF, 32'hFFFF_FFFC);
    check("wrap0.pc8_d", pc8_d, 32'h4);
    check("wrap0.im_addr", {22'd0, im_addr}, 32'd0);

    // long stall raises stuck at run length 16
    stop = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 15) check("run15.stuck", {31'd0, stuck}, 32'd0);
      if (k == 16) check("run16.stuck", {31'd0, stuck}, 32'd1);
    end
    check("run20.stuck", {31'd0, stuck}, 32'd1);
    check("run20.cnt", stall_cnt, 32'd23);
    check("run20.pc_f", pc_f, 32'h0);
    stop = 1'b0;
    step();
    check("release.stuck", {31'd0, stuck}, 32'd0);
    check("release.cnt", stall_cnt, 32'd23);
    check_pipe("release", 32'h4, word_at(32'h0), 32'h0);

    // reset in the middle of a stall with a pending redirect
    stop = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h3400;
    step();
    step();
    check("prereset.cnt", stall_cnt, 32'd25);
    reset = 1'b1;
    step();
    check_pipe("midreset", 32'h3000, 32'h0, 32'h3000);
    check("midreset.cnt", stall_cnt, 32'd0);
    check("midreset.stuck", {31'd0, stuck}, 32'd0);
    reset = 1'b0;
    stop = 1'b0;
    redirect = 1'b0;
    step();
    check_pipe("postreset", 32'h3004, 32'hA000_0000, 32'h3000);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
